rat_ckpt: RTL and testbench
===========================

# rat_ckpt

Parametrised register alias table for the OOO core. Renames RENAME_WIDTH instructions per cycle with intra-group bypass, and tracks per-physical-register ready bits from NUM_WB writeback ports. Holds a NUM_CKPT-deep in-order ring of branch checkpoints, so a mispredict restores the mapping in one cycle instead of waiting for a full RRF flush. Sits between decode/free list and the reservation stations.

## Interface
- NUM_REGS, 64, physical register count; preg width P = $clog2(NUM_REGS).
- RENAME_WIDTH, 2, rename slots per cycle.
- NUM_WB, 3, writeback ports (alu, mul, ldst).
- NUM_CKPT, 4, checkpoint entries; power of 2; id width C = $clog2(NUM_CKPT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ren_valid  in  [RENAME_WIDTH]  slot holds a renaming instruction
- ren_rs1, ren_rs2, ren_rd  in  [RENAME_WIDTH][5]  arch sources and destination
- ren_pd  in  [RENAME_WIDTH][P]  free-list physical destination
- ren_ps1, ren_ps2  out  [RENAME_WIDTH][P]  physical sources
- ren_rdy1, ren_rdy2  out  [RENAME_WIDTH]  source operand ready
- wb_valid  in  [NUM_WB]  writeback strobe
- wb_rd  in  [NUM_WB][5]  arch destination of the writeback
- wb_pd  in  [NUM_WB][P]  physical register written back
- ckpt_req  in  1  snapshot the post-group mapping this cycle
- ckpt_id  out  C  id assigned to the current ckpt_req (tail pointer)
- ckpt_full, ckpt_empty  out  1  ring status
- ckpt_free  in  1  oldest branch resolved correctly; release head
- restore_valid  in  1  mispredict
- restore_id  in  C  checkpoint to restore
- flush  in  1  full recovery from RRF
- rrf_map  in  [32][P]  committed mapping
- swap  in  1  hardware-scheduler thread swap

## Operation
- Rename lookup:
  - Slot i source reads the table.
  - It is overridden by the highest-numbered earlier slot j<i with ren_valid[j] and ren_rd[j]==src, which returns ren_pd[j] and ready=0.
  - x0 always maps to p0, ready=1.
- Ready for a non-bypassed source is ready_vec[p] OR any wb_valid[k] with wb_pd[k]==p and wb_rd[k]!=0 in the same cycle.
- Mapping update: for each valid slot with ren_rd!=0, set map[rd]<=pd and ready_vec[pd]<=0. If two slots target the same rd, the later slot wins.
- Writeback sets ready_vec[wb_pd]<=1 when wb_rd!=0. Set is applied after rename clear, so set wins on a collision.
- Checkpoint ring:
  - head/tail pointers plus a count of width C+1.
  - ckpt_req with !ckpt_full writes the post-rename-group mapping into entry tail, then increments tail and count.
  - Decode places a branch last in its group.
  - ckpt_free increments head and decrements count.
- Restore:
  - map <= snap[restore_id].
  - tail <= restore_id+1 (mod NUM_CKPT); count recomputed from head; younger checkpoints are discarded.
  - Renames and ckpt_req in the same cycle are ignored.
  - ready_vec is unchanged.
- Flush: map <= rrf_map; ready_vec all 1; head=tail=count=0.
- rst or swap: identity map (xN->pN), ready_vec all 1, ring empty.
- Priority: rst/swap > flush > restore > (ckpt_free, then rename/ckpt_req). ckpt_free is still applied alongside restore, before the tail recompute.
- ckpt_req while ckpt_full is dropped (no state change); the bench flags it as an assertion.

## Timing
- Lookups and ready outputs are combinational from current state plus same-cycle bypass.
- Mapping, ready and checkpoint updates are visible the next cycle. A snapshot taken at edge N is restorable from cycle N+1.
- Restore and flush complete in one cycle. The first rename after them sees the recovered map.
- Reset outputs: ren_ps* = identity lookup of the inputs, ren_rdy* = 1, ckpt_id=0, ckpt_empty=1, ckpt_full=0.
- ckpt_full/ckpt_empty are registered-state derived and do not reflect same-cycle req/free.
- Pointers wrap modulo NUM_CKPT. Full is count==NUM_CKPT.

## Structure
- rv32i_types holds NUM_REGS, plus new defaults for RENAME_WIDTH, NUM_CKPT and NUM_WB.
- rv32i_types also holds typedefs preg_t (logic [P-1:0]), ckpt_id_t, and map_t (preg_t [32]).
- Sub-module rat_ckpt_store is the snapshot RAM: NUM_CKPT x map_t with a write port (tail) and a read port (restore_id). Pointers and count stay in rat_ckpt.

## Test plan
- Reset, then rename x5<-p40 in slot0 and read x5 in slot1 in the same cycle -> slot1 ren_ps1=40, rdy1=0. Next cycle, slot0 reading x5 -> 40, rdy 0.
- wb_valid[1] with wb_pd=40 in the same cycle a slot reads x5 -> rdy=1. The following cycle ready_vec[40]=1.
- Both slots write x7 (p41, p42) -> next-cycle lookup of x7 returns 42.
- Rename x3<-p50 with ckpt_req (id 0), then x3<-p51, then restore_valid id 0 -> x3 reads 50 and the ring is empty again if head was 0.
- Four ckpt_req -> ckpt_full=1. A fifth is dropped. ckpt_free -> count 3; wrap the tail to id 0 and verify the snapshot.
- Flush with rrf_map[3]=60 concurrent with restore and rename -> x3=60, all ready, ring empty. swap mid-stream -> identity map.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: physical register file size, rename/writeback widths,
// checkpoint ring depth and the derived register/checkpoint/map types.
package rv32i_types;

    localparam int NUM_REGS     = 64;
    localparam int RENAME_WIDTH = 2;
    localparam int NUM_WB       = 3;
    localparam int NUM_CKPT     = 4;

    localparam int P = $clog2(NUM_REGS);
    localparam int C = $clog2(NUM_CKPT);

    typedef logic [P-1:0]  preg_t;
    typedef logic [C-1:0]  ckpt_id_t;
    typedef preg_t [31:0]  map_t;

endpackage

// File: rtl/rat_ckpt_store.sv
// Snapshot storage for the branch checkpoint ring: one full arch->phys map
// per entry, written at the ring tail and read asynchronously on restore.
module rat_ckpt_store
    import rv32i_types::*;
#(
    parameter int NUM_CKPT = rv32i_types::NUM_CKPT,
    parameter int PW       = rv32i_types::P,
    localparam int C       = $clog2(NUM_CKPT)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [C-1:0]          waddr,
    input  logic [31:0][PW-1:0]   wdata,
    input  logic [C-1:0]          raddr,
    output logic [31:0][PW-1:0]   rdata
);

    logic [31:0][PW-1:0] mem [NUM_CKPT];

    // Capture the post-rename-group mapping into the tail entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with same-group bypass, per-preg ready tracking and a
// ring of branch checkpoints allowing single-cycle mispredict recovery.
module rat_ckpt
    import rv32i_types::*;
#(
    parameter int NUM_REGS     = rv32i_types::NUM_REGS,
    parameter int RENAME_WIDTH = rv32i_types::RENAME_WIDTH,
    parameter int NUM_WB       = rv32i_types::NUM_WB,
    parameter int NUM_CKPT     = rv32i_types::NUM_CKPT,
    localparam int P           = $clog2(NUM_REGS),
    localparam int C           = $clog2(NUM_CKPT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [RENAME_WIDTH-1:0]            ren_valid,
    input  logic [RENAME_WIDTH-1:0][4:0]       ren_rs1,
    input  logic [RENAME_WIDTH-1:0][4:0]       ren_rs2,
    input  logic [RENAME_WIDTH-1:0][4:0]       ren_rd,
    input  logic [RENAME_WIDTH-1:0][P-1:0]     ren_pd,
    output logic [RENAME_WIDTH-1:0][P-1:0]     ren_ps1,
    output logic [RENAME_WIDTH-1:0][P-1:0]     ren_ps2,
    output logic [RENAME_WIDTH-1:0]            ren_rdy1,
    output logic [RENAME_WIDTH-1:0]            ren_rdy2,
    input  logic [NUM_WB-1:0]                  wb_valid,
    input  logic [NUM_WB-1:0][4:0]             wb_rd,
    input  logic [NUM_WB-1:0][P-1:0]           wb_pd,
    input  logic                               ckpt_req,
    output logic [C-1:0]                       ckpt_id,
    output logic                               ckpt_full,
    output logic                               ckpt_empty,
    input  logic                               ckpt_free,
    input  logic                               restore_valid,
    input  logic [C-1:0]                       restore_id,
    input  logic                               flush,
    input  logic [31:0][P-1:0]                 rrf_map,
    input  logic                               swap
);

    logic [31:0][P-1:0]  map_q;
    logic [NUM_REGS-1:0] ready_q;
    logic [C-1:0]        head_q;
    logic [C-1:0]        tail_q;
    logic [C:0]          count_q;

    logic [31:0][P-1:0]  map_grp;
    logic [31:0][P-1:0]  map_id;
    logic [31:0][P-1:0]  snap_rd;
    logic [NUM_REGS-1:0] ready_ren;
    logic [NUM_REGS-1:0] ready_wb;
    logic                free_ok;
    logic                req_ok;
    logic                snap_we;
    logic [C-1:0]        head_adv;

    // Same-cycle writeback to a physical register (x0 writebacks never count).
    function automatic logic wb_hit(input logic [P-1:0]            p,
                                    input logic [NUM_WB-1:0]       v,
                                    input logic [NUM_WB-1:0][4:0]  rd,
                                    input logic [NUM_WB-1:0][P-1:0] pd);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (v[k] && (rd[k] != 5'd0) && (pd[k] == p)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign ckpt_full  = (count_q == (C+1)'(NUM_CKPT));
    assign ckpt_empty = (count_q == '0);
    assign ckpt_id    = tail_q;
    assign free_ok    = ckpt_free && !ckpt_empty;
    assign req_ok     = ckpt_req && !ckpt_full;
    assign head_adv   = head_q + C'(free_ok);
    assign snap_we    = !(rst || swap) && !flush && !restore_valid && req_ok;

    // Source lookup: table read, overridden by the youngest earlier slot that
    // writes the same arch register; x0 is hardwired to p0 and always ready.
    always_comb begin
        ren_ps1  = '0;
        ren_ps2  = '0;
        ren_rdy1 = '0;
        ren_rdy2 = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            ren_ps1[i]  = map_q[ren_rs1[i]];
            ren_ps2[i]  = map_q[ren_rs2[i]];
            ren_rdy1[i] = ready_q[ren_ps1[i]] | wb_hit(ren_ps1[i], wb_valid, wb_rd, wb_pd);
            ren_rdy2[i] = ready_q[ren_ps2[i]] | wb_hit(ren_ps2[i], wb_valid, wb_rd, wb_pd);
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                if (j < i && ren_valid[j] && ren_rd[j] == ren_rs1[i]) begin
                    ren_ps1[i]  = ren_pd[j];
                    ren_rdy1[i] = 1'b0;
                end
                if (j < i && ren_valid[j] && ren_rd[j] == ren_rs2[i]) begin
                    ren_ps2[i]  = ren_pd[j];
                    ren_rdy2[i] = 1'b0;
                end
            end
            if (ren_rs1[i] == 5'd0) begin
                ren_ps1[i]  = '0;
                ren_rdy1[i] = 1'b1;
            end
            if (ren_rs2[i] == 5'd0) begin
                ren_ps2[i]  = '0;
                ren_rdy2[i] = 1'b1;
            end
        end
    end

    // Post-group mapping and ready vector; later slots win, writeback set
    // is applied after the rename clear so it wins on a collision.
    always_comb begin
        map_grp   = map_q;
        ready_ren = ready_q;
        ready_wb  = ready_q;
        for (int r = 0; r < 32; r++) begin
            map_id[r] = r[P-1:0];
        end
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (ren_valid[i] && ren_rd[i] != 5'd0) begin
                map_grp[ren_rd[i]]   = ren_pd[i];
                ready_ren[ren_pd[i]] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_rd[k] != 5'd0) begin
                ready_ren[wb_pd[k]] = 1'b1;
                ready_wb[wb_pd[k]]  = 1'b1;
            end
        end
    end

    // Mapping and ready state: reset/swap > flush > restore > rename.
    always_ff @(posedge clk) begin
        if (rst || swap) begin
            map_q   <= map_id;
            ready_q <= '1;
        end else if (flush) begin
            map_q   <= rrf_map;
            ready_q <= '1;
        end else if (restore_valid) begin
            map_q   <= snap_rd;
            ready_q <= ready_wb;
        end else begin
            map_q   <= map_grp;
            ready_q <= ready_ren;
        end
    end

    // Checkpoint ring pointers; a restore discards the restored entry and
    // everything younger, so the live count is the distance head..restore_id.
    always_ff @(posedge clk) begin
        if (rst || swap || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (restore_valid) begin
            head_q  <= head_adv;
            tail_q  <= restore_id + C'(1);
            count_q <= {1'b0, C'(restore_id - head_adv)};
        end else begin
            head_q  <= head_adv;
            tail_q  <= tail_q + C'(req_ok);
            count_q <= count_q + (C+1)'(req_ok) - (C+1)'(free_ok);
        end
    end

    rat_ckpt_store #(
        .NUM_CKPT (NUM_CKPT),
        .PW       (P)
    ) u_store (
        .clk   (clk),
        .we    (snap_we),
        .waddr (tail_q),
        .wdata (map_grp),
        .raddr (restore_id),
        .rdata (snap_rd)
    );

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: expected values are queued as stimulus is
// applied and checked in order against the DUT outputs mid-cycle.
module tb_rat_ckpt;

    localparam int RW  = 2;
    localparam int NWB = 3;
    localparam int P   = 6;
    localparam int C   = 2;

    logic                     clk;
    logic                     rst;
    logic [RW-1:0]            ren_valid;
    logic [RW-1:0][4:0]       ren_rs1, ren_rs2, ren_rd;
    logic [RW-1:0][P-1:0]     ren_pd;
    logic [RW-1:0][P-1:0]     ren_ps1, ren_ps2;
    logic [RW-1:0]            ren_rdy1, ren_rdy2;
    logic [NWB-1:0]           wb_valid;
    logic [NWB-1:0][4:0]      wb_rd;
    logic [NWB-1:0][P-1:0]    wb_pd;
    logic                     ckpt_req;
    logic [C-1:0]             ckpt_id;
    logic                     ckpt_full, ckpt_empty;
    logic                     ckpt_free;
    logic                     restore_valid;
    logic [C-1:0]             restore_id;
    logic                     flush;
    logic [31:0][P-1:0]       rrf_map;
    logic                     swap;

    rat_ckpt dut (
        .clk           (clk),
        .rst           (rst),
        .ren_valid     (ren_valid),
        .ren_rs1       (ren_rs1),
        .ren_rs2       (ren_rs2),
        .ren_rd        (ren_rd),
        .ren_pd        (ren_pd),
        .ren_ps1       (ren_ps1),
        .ren_ps2       (ren_ps2),
        .ren_rdy1      (ren_rdy1),
        .ren_rdy2      (ren_rdy2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_pd         (wb_pd),
        .ckpt_req      (ckpt_req),
        .ckpt_id       (ckpt_id),
        .ckpt_full     (ckpt_full),
        .ckpt_empty    (ckpt_empty),
        .ckpt_free     (ckpt_free),
        .restore_valid (restore_valid),
        .restore_id    (restore_id),
        .flush         (flush),
        .rrf_map       (rrf_map),
        .swap          (swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0d required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        ren_valid     = '0;
        ren_rs1       = '0;
        ren_rs2       = '0;
        ren_rd        = '0;
        ren_pd        = '0;
        wb_valid      = '0;
        wb_rd         = '0;
        wb_pd         = '0;
        ckpt_req      = 1'b0;
        ckpt_free     = 1'b0;
        restore_valid = 1'b0;
        restore_id    = '0;
        flush         = 1'b0;
        swap          = 1'b0;
        for (int r = 0; r < 32; r++) rrf_map[r] = 6'(r);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        next_cycle();

        // Reset state and identity lookup
        ren_rs1[0] = 5'd5;
        ren_rs2[1] = 5'd0;
        ren_rs1[1] = 5'd31;
        expect_v("rst_ps1_0", 5);
        expect_v("rst_rdy1_0", 1);
        expect_v("rst_ps2_1", 0);
        expect_v("rst_rdy2_1", 1);
        expect_v("rst_ps1_1", 31);
        expect_v("rst_ckpt_id", 0);
        expect_v("rst_empty", 1);
        expect_v("rst_full", 0);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps2[1]));
        observe(32'(ren_rdy2[1]));
        observe(32'(ren_ps1[1]));
        observe(32'(ckpt_id));
        observe(32'(ckpt_empty));
        observe(32'(ckpt_full));

        // x5 <- p40 in slot0, slot1 reads x5 via bypass
        next_cycle();
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd5; ren_pd[0] = 6'd40;
        ren_rs1[0] = 5'd5;
        ren_rs1[1] = 5'd5; ren_rs2[1] = 5'd5;
        expect_v("self_ps1_0", 5);
        expect_v("byp_ps1_1", 40);
        expect_v("byp_rdy1_1", 0);
        expect_v("byp_ps2_1", 40);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_ps1[1]));
        observe(32'(ren_rdy1[1]));
        observe(32'(ren_ps2[1]));

        // Table now holds x5->p40, not ready; then same-cycle writeback
        next_cycle();
        ren_rs1[0] = 5'd5;
        expect_v("map_x5", 40);
        expect_v("map_x5_rdy", 0);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        wb_valid[1] = 1'b1; wb_rd[1] = 5'd5; wb_pd[1] = 6'd40;
        expect_v("wb_fwd_rdy", 1);
        #1;
        observe(32'(ren_rdy1[0]));

        // Writeback registered; both slots write x7
        next_cycle();
        ren_rs1[0] = 5'd5;
        ren_valid = 2'b11;
        ren_rd[0] = 5'd7; ren_pd[0] = 6'd41;
        ren_rd[1] = 5'd7; ren_pd[1] = 6'd42;
        ren_rs1[1] = 5'd7;
        expect_v("wb_reg_rdy", 1);
        expect_v("byp_x7_slot1", 41);
        #1;
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps1[1]));

        // Later slot won x7; x0 rename ignored; x0 writeback ignored
        next_cycle();
        ren_rs1[0] = 5'd7;
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd0; ren_pd[0] = 6'd45;
        ren_rs1[1] = 5'd0; ren_rs2[1] = 5'd7;
        wb_valid[0] = 1'b1; wb_rd[0] = 5'd0; wb_pd[0] = 6'd42;
        expect_v("x7_later_wins", 42);
        expect_v("x7_rdy_x0wb", 0);
        expect_v("x0_ps", 0);
        expect_v("x0_rdy", 1);
        expect_v("x7_slot1_no_x0byp", 42);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps1[1]));
        observe(32'(ren_rdy1[1]));
        observe(32'(ren_ps2[1]));

        // x3 <- p50 with checkpoint
        next_cycle();
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd3; ren_pd[0] = 6'd50;
        ckpt_req = 1'b1;
        expect_v("ckpt_id_first", 0);
        #1;
        observe(32'(ckpt_id));

        next_cycle();
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd3; ren_pd[0] = 6'd51;
        expect_v("after_req_empty", 0);
        expect_v("after_req_id", 1);
        #1;
        observe(32'(ckpt_empty));
        observe(32'(ckpt_id));

        // Restore id 0 with an ignored rename and request
        next_cycle();
        ren_rs1[0] = 5'd3;
        restore_valid = 1'b1; restore_id = 2'd0;
        ren_valid[1] = 1'b1; ren_rd[1] = 5'd3; ren_pd[1] = 6'd55;
        ckpt_req = 1'b1;
        expect_v("pre_restore_x3", 51);
        #1;
        observe(32'(ren_ps1[0]));

        next_cycle();
        ren_rs1[0] = 5'd3; ren_rs2[0] = 5'd7;
        expect_v("restored_x3", 50);
        expect_v("restored_x3_rdy", 0);
        expect_v("restored_x7", 42);
        expect_v("restore_empty", 1);
        expect_v("restore_tail", 1);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps2[0]));
        observe(32'(ckpt_empty));
        observe(32'(ckpt_id));

        // Fill the ring; tail wraps through 0
        for (int n = 0; n < 4; n++) begin
            if (n != 0) next_cycle();
            ren_valid[0] = 1'b1; ren_rd[0] = 5'd9; ren_pd[0] = 6'(30 + n);
            ckpt_req = 1'b1;
            expect_v($sformatf("fill_id_%0d", n), (1 + n) % 4);
            #1;
            observe(32'(ckpt_id));
        end
        next_cycle();
        expect_v("ring_full", 1);
        expect_v("ring_not_empty", 0);
        #1;
        observe(32'(ckpt_full));
        observe(32'(ckpt_empty));

        // Request while full is dropped
        ckpt_req = 1'b1;
        next_cycle();
        expect_v("drop_id", 1);
        expect_v("drop_full", 1);
        #1;
        observe(32'(ckpt_id));
        observe(32'(ckpt_full));

        // Release the head, rename x9 again, then restore the wrapped entry
        ckpt_free = 1'b1;
        next_cycle();
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd9; ren_pd[0] = 6'd36;
        expect_v("free_full", 0);
        expect_v("free_empty", 0);
        #1;
        observe(32'(ckpt_full));
        observe(32'(ckpt_empty));
        next_cycle();
        restore_valid = 1'b1; restore_id = 2'd0;
        next_cycle();
        ren_rs1[0] = 5'd9; ren_rs2[0] = 5'd3;
        expect_v("wrap_snap_x9", 33);
        expect_v("wrap_snap_x3", 50);
        expect_v("wrap_full", 0);
        expect_v("wrap_empty", 0);
        expect_v("wrap_tail", 1);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_ps2[0]));
        observe(32'(ckpt_full));
        observe(32'(ckpt_empty));
        observe(32'(ckpt_id));

        // Flush beats concurrent restore, rename and request
        flush = 1'b1;
        rrf_map[3] = 6'd60;
        restore_valid = 1'b1; restore_id = 2'd2;
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd3; ren_pd[0] = 6'd1;
        ckpt_req = 1'b1;
        next_cycle();
        ren_rs1[0] = 5'd3; ren_rs2[0] = 5'd9; ren_rs1[1] = 5'd7;
        expect_v("flush_x3", 60);
        expect_v("flush_x3_rdy", 1);
        expect_v("flush_x9", 9);
        expect_v("flush_x9_rdy", 1);
        expect_v("flush_x7", 7);
        expect_v("flush_empty", 1);
        expect_v("flush_full", 0);
        expect_v("flush_id", 0);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps2[0]));
        observe(32'(ren_rdy2[0]));
        observe(32'(ren_ps1[1]));
        observe(32'(ckpt_empty));
        observe(32'(ckpt_full));
        observe(32'(ckpt_id));

        // Rename x4, then thread swap restores identity
        ren_valid[0] = 1'b1; ren_rd[0] = 5'd4; ren_pd[0] = 6'd20;
        ckpt_req = 1'b1;
        next_cycle();
        ren_rs1[0] = 5'd4;
        expect_v("pre_swap_x4", 20);
        expect_v("pre_swap_x4_rdy", 0);
        expect_v("pre_swap_id", 1);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ckpt_id));
        swap = 1'b1;
        ckpt_req = 1'b1;
        next_cycle();
        ren_rs1[0] = 5'd4; ren_rs1[1] = 5'd3;
        expect_v("swap_x4", 4);
        expect_v("swap_x4_rdy", 1);
        expect_v("swap_x3", 3);
        expect_v("swap_id", 0);
        expect_v("swap_empty", 1);
        #1;
        observe(32'(ren_ps1[0]));
        observe(32'(ren_rdy1[0]));
        observe(32'(ren_ps1[1]));
        observe(32'(ckpt_id));
        observe(32'(ckpt_empty));

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover: observed %0d pending required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
